// File: rtl/gcd_datapath_pkg.sv
// gcd_datapath_pkg: shared width default and operand-load status codes for the GCD datapath and its FSM
package gcd_datapath_pkg;
   localparam int         GCD_W    = 8;
   localparam logic [1:0] CLD_NONE = 2'b00;
   localparam logic [1:0] CLD_X    = 2'b01;
   localparam logic [1:0] CLD_FULL = 2'b11;
endpackage

// File: rtl/gcd_result_port.sv
// gcd_result_port: gld edge detect, result latch and valid/ready hold
//   clk, clr        clock, synchronous active-high reset
//   gld             latch request (level; only its rising edge captures)
//   x, y            working registers; result is x, or y when x is zero
//   gcd_valid/out   result port, held stable until gcd_ready
//   gcd_ready       consumer ready
//   accept          result consumed this cycle (gcd_valid & gcd_ready)
module gcd_result_port
   import gcd_datapath_pkg::*;
#(
   parameter int W = GCD_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         gld,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         gcd_ready,
   output logic         gcd_valid,
   output logic [W-1:0] gcd_out,
   output logic         accept
);
   logic         gld_q, valid_q, valid_d, cap;
   logic [W-1:0] out_q, out_d;
   always_comb begin
      cap     = gld & ~gld_q & ~valid_q;
      valid_d = cap | (valid_q & ~gcd_ready);
      out_d   = cap ? ((x == '0) ? y : x) : out_q;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         gld_q   <= 1'b0;
         valid_q <= 1'b0;
         out_q   <= '0;
      end else begin
         gld_q   <= gld;
         valid_q <= valid_d;
         out_q   <= out_d;
      end
   end
   assign gcd_valid = valid_q;
   assign gcd_out   = out_q;
   assign accept    = valid_q & gcd_ready;
endmodule

// File: rtl/gcd_datapath.sv
// gcd_datapath: GCD datapath -- operand loader, x/y working registers, status flags, result port
//   clk, clr                  clock, synchronous active-high reset
//   in_valid/in_data/in_ready operand beats: first beat is x, second is y
//   xld, yld, xmsel, ymsel    FSM load commands (sel 1 = staged operand, 0 = difference)
//   gld                       FSM result latch request
//   eqflg, ltflg, cld         status to FSM: terminate, y<x, operand-load status
//   gcd_valid/gcd_out/gcd_ready result port
module gcd_datapath
   import gcd_datapath_pkg::*;
#(
   parameter int W = GCD_W
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   input  logic         xld,
   input  logic         yld,
   input  logic         xmsel,
   input  logic         ymsel,
   input  logic         gld,
   output logic         eqflg,
   output logic         ltflg,
   output logic [1:0]   cld,
   output logic         gcd_valid,
   output logic [W-1:0] gcd_out,
   input  logic         gcd_ready
);
   logic [W-1:0] x_q, x_d, y_q, y_d, xin_q, xin_d, yin_q, yin_d;
   logic [1:0]   cld_q, cld_d;
   logic         cap_x, cap_y, out_acc;
   // Beat capture overrides FSM commands for the register it writes.
   always_comb begin
      cap_x = in_valid & in_ready & (cld_q == CLD_NONE);
      cap_y = in_valid & in_ready & (cld_q == CLD_X);
      x_d   = cap_x ? in_data : xld ? (xmsel ? xin_q : x_q - y_q) : x_q;
      y_d   = cap_y ? in_data : yld ? (ymsel ? yin_q : y_q - x_q) : y_q;
      xin_d = cap_x ? in_data : xin_q;
      yin_d = cap_y ? in_data : yin_q;
      cld_d = out_acc ? CLD_NONE : cap_x ? CLD_X : cap_y ? CLD_FULL : cld_q;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         x_q   <= '0;
         y_q   <= '0;
         xin_q <= '0;
         yin_q <= '0;
         cld_q <= CLD_NONE;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         xin_q <= xin_d;
         yin_q <= yin_d;
         cld_q <= cld_d;
      end
   end
   // A zero operand terminates too, otherwise subtraction would never converge.
   assign eqflg    = (x_q == y_q) | (x_q == '0) | (y_q == '0);
   assign ltflg    = y_q < x_q;
   assign in_ready = cld_q != CLD_FULL;
   assign cld      = cld_q;
   gcd_result_port #(.W(W)) u_result (
      .clk       (clk),
      .clr       (clr),
      .gld       (gld),
      .x         (x_q),
      .y         (y_q),
      .gcd_ready (gcd_ready),
      .gcd_valid (gcd_valid),
      .gcd_out   (gcd_out),
      .accept    (out_acc)
   );
endmodule

// File: tb/tb_gcd_datapath.sv
// tb_gcd_datapath: randomized and directed checks of gcd_datapath against a behavioural model
module tb_gcd_datapath;
   logic       clk = 0, clr = 1, in_valid = 0, xld = 0, yld = 0, xmsel = 0, ymsel = 0, gld = 0, gcd_ready = 0;
   logic [7:0] in_data = 0;
   logic       in_ready, eqflg, ltflg, gcd_valid;
   logic [1:0] cld;
   logic [7:0] gcd_out;
   int ncmp = 0, nerr = 0;
   bit armed = 0;
   // model state: working values, staged operands, beats taken, result port
   int mx, my, mxin, myin, nb, mv, mo, mg;
   gcd_datapath #(.W(8)) dut (
      .clk(clk), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .xld(xld), .yld(yld), .xmsel(xmsel), .ymsel(ymsel), .gld(gld),
      .eqflg(eqflg), .ltflg(ltflg), .cld(cld),
      .gcd_valid(gcd_valid), .gcd_out(gcd_out), .gcd_ready(gcd_ready)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input int act, input int exp);
      ncmp++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask
   function automatic int gcd_ref(input int a, input int b);
      int t;
      while (b != 0) begin
         t = a % b;
         a = b;
         b = t;
      end
      return a;
   endfunction
   always @(posedge clk) begin
      int nx, ny;
      if (clr) begin
         mx = 0; my = 0; mxin = 0; myin = 0; nb = 0; mv = 0; mo = 0; mg = 0;
      end else begin
         nx = mx;
         ny = my;
         if (xld) nx = xmsel ? mxin : (mx - my) & 255;
         if (yld) ny = ymsel ? myin : (my - mx) & 255;
         if (in_valid && nb < 2) begin
            if (nb == 0) begin nx = in_data; mxin = in_data; end
            else begin ny = in_data; myin = in_data; end
            nb++;
         end
         if (mv == 1 && gcd_ready) begin
            mv = 0;
            nb = 0;
         end else if (gld && mg == 0 && mv == 0) begin
            mo = (mx == 0) ? my : mx;
            mv = 1;
         end
         mg = gld;
         mx = nx;
         my = ny;
      end
   end
   always @(negedge clk) begin
      if (armed) begin
         chk("in_ready", in_ready, nb < 2);
         chk("cld", cld, nb == 0 ? 0 : nb == 1 ? 1 : 3);
         chk("eqflg", eqflg, mx == my || mx == 0 || my == 0);
         chk("ltflg", ltflg, my < mx);
         chk("gcd_valid", gcd_valid, mv);
         chk("gcd_out", gcd_out, mo);
      end
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic load(input int a, input int b);
      in_valid = 1; in_data = 8'(a); cyc();
      in_data = 8'(b); cyc();
      in_valid = 0;
   endtask
   // behavioural control FSM: subtract until terminate, then raise gld
   task automatic run_fsm(output int res);
      int i;
      for (i = 0; i < 600 && !eqflg; i++) begin
         xld = ltflg; xmsel = 0;
         yld = !ltflg; ymsel = 0;
         cyc();
      end
      xld = 0; yld = 0;
      if (i == 600) chk("fsm_timeout", 0, 1);
      gld = 1;
      cyc();
      chk("valid_after_gld", gcd_valid, 1);
      res = gcd_out;
   endtask
   task automatic take();
      gcd_ready = 1; cyc();
      gcd_ready = 0; gld = 0;
      chk("valid_dropped", gcd_valid, 0);
      chk("cld_cleared", cld, 0);
   endtask
   initial begin
      int r, a, b;
      cyc(); cyc();
      clr = 0;
      armed = 1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_cld", cld, 0);
      chk("rst_valid", gcd_valid, 0);
      // 12,18 -> 6
      load(12, 18);
      run_fsm(r);
      chk("gcd_12_18", r, 6);
      take();
      // zero operands
      load(0, 9);
      chk("eq_zero_x", eqflg, 1);
      run_fsm(r);
      chk("gcd_0_9", r, 9);
      take();
      load(0, 0);
      run_fsm(r);
      chk("gcd_0_0", r, 0);
      take();
      // three beats held: third is refused
      in_valid = 1; in_data = 5; cyc();
      in_data = 7; cyc();
      chk("in_ready_full", in_ready, 0);
      in_data = 99; cyc();
      in_valid = 0;
      run_fsm(r);
      chk("gcd_5_7", r, 1);
      take();
      xld = 1; xmsel = 1; yld = 1; ymsel = 1; cyc();
      xld = 0; yld = 0;
      chk("staged_x", mx, 5);
      chk("staged_y", my, 7);
      chk("staged_lt", ltflg, 0);
      // clr mid-run, with a beat offered in the clr cycle
      load(255, 1);
      xld = 1; xmsel = 0;
      repeat (3) cyc();
      xld = 0;
      chk("sub3_x", mx, 252);
      clr = 1; in_valid = 1; in_data = 77; cyc();
      clr = 0; in_valid = 0;
      chk("clr_cld", cld, 0);
      chk("clr_valid", gcd_valid, 0);
      chk("clr_in_ready", in_ready, 1);
      chk("clr_eq", eqflg, 1);
      // held gld with consumer stalled
      load(48, 36);
      run_fsm(r);
      repeat (10) cyc();
      chk("stall_valid", gcd_valid, 1);
      chk("stall_out", gcd_out, 12);
      take();
      chk("stall_in_ready", in_ready, 1);
      // simultaneous subtract with wrap
      load(20, 8);
      chk("lt_before", ltflg, 1);
      xld = 1; yld = 1; xmsel = 0; ymsel = 0; cyc();
      xld = 0; yld = 0;
      chk("wrap_x", mx, 12);
      chk("wrap_y", my, 244);
      chk("lt_after", ltflg, 0);
      run_fsm(r);
      take();
      // randomized pairs with random consumer stall
      repeat (25) begin
         a = $urandom_range(0, 255);
         b = $urandom_range(0, 255);
         load(a, b);
         run_fsm(r);
         chk("gcd_rand", r, gcd_ref(a, b));
         repeat ($urandom_range(0, 4)) cyc();
         take();
      end
      armed = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end
endmodule
